exec_unit: RTL and testbench
============================

// Module: exec_unit
// PURPOSE
//  Parametrised, stateful successor to the combinational 4-bit ALU.
//  - Holds the architectural registers A, B, OUT, PC and flags C/Z internally.
//  - Accepts one instruction per handshake and commits it.
//  - Adds SUB/ADD-reg/shift/JZ ops and a multi-cycle MUL_A_B (shift-add, DATA_W cycles).
//  - Sits between instruction fetch/decode and the board I/O (switches, LEDs).
// PARAMETERS
//  DATA_W  4  width of A, B, OUT, imm and switch input
//  PC_W    4  program-counter width; jump targets use imm[PC_W-1:0]
// PORTS
//  clk          in   1       single clock; all state updates on rising edge
//  rst          in   1       synchronous, active-high reset
//  instr_valid  in   1       opecode/imm valid this cycle
//  instr_ready  out  1       unit can accept an instruction
//  opecode      in   OPECODE 5-bit opcode enum from lib_operation
//  imm          in   DATA_W  immediate operand
//  switch_in    in   DATA_W  input port sampled by IN_A/IN_B
//  a_q, b_q     out  DATA_W  register A / B
//  out_q        out  DATA_W  output port register
//  pc_q         out  PC_W    program counter
//  c_q, z_q     out  1       carry/borrow flag, zero flag
//  done         out  1       one-cycle pulse: an instruction has committed
// BEHAVIOUR
//  Reset: a_q=b_q=out_q=pc_q=0, c_q=z_q=0, done=0, state IDLE, instr_ready=1.
//   rst wins over every other event, including an in-flight MUL, which is aborted.
//  Accept: instr_valid && instr_ready at a rising edge.
//   instr_valid while instr_ready=0 is ignored; there is no queueing.
//  Single-cycle ops (everything except MUL_A_B):
//   - all state updates on the accepting edge; done=1 in the following cycle.
//   - instr_ready stays 1, so back-to-back accepts run at 1 instr/cycle.
//  Ops, all arithmetic mod 2^DATA_W:
//   - MOV_A_B, MOV_B_A, MOV_A_IMM, MOV_B_IMM, IN_A, IN_B, OUT_B, OUT_IMM
//   - ADD_A_IMM, ADD_B_IMM, ADD_A_B (A=A+B), SUB_A_B (A=A-B)
//   - SHL_A (C=A[MSB]), SHR_A (C=A[0]); vacated bit is 0 for both
//   - JMP_IMM; JNC_IMM (jump if C==0); JZ_IMM (jump if Z==1); NOP, also used for any undefined code
//  Flags:
//   - ADD: C = carry-out; SUB: C = borrow.
//   - ADD/SUB/SHx: Z = (result==0).
//   - Every other op clears C and leaves Z unchanged.
//   - JNC/JZ test the flags as they were before the instruction.
//  PC: taken jump -> PC = imm[PC_W-1:0]; otherwise PC+1, wrapping 2^PC_W-1 -> 0.
//  MUL_A_B FSM, states IDLE -> MUL -> IDLE:
//   - Accept: latch multiplicand/multiplier, clear accumulator, cnt=0, instr_ready=0.
//   - MUL: one shift-add step per cycle; after DATA_W steps return to IDLE.
//   - Commit: {B,A} = full 2*DATA_W-bit product; C=0; Z=(product==0); PC+1.
//   - done pulses the cycle after commit; instr_ready=1 again in that same cycle.
//   - Commit latency: DATA_W cycles after accept; A/B remain visible unchanged until commit.
// STRUCTURE
//  lib_operation package:
//   - OPECODE enum (5 bits) and encodings for all ops above
//   - state enum {IDLE, MUL}
//   - pure per-op next-state functions on a REGS struct
//  Sub-module: seq_multiplier (DATA_W-parametrised shift-add core)
//   - ports: start, a, b, busy, done, product[2*DATA_W-1:0]
//  exec_unit owns the register file, flags, PC and the handshake.
// TESTING (DATA_W=4, PC_W=4)
//  1. Reset -> all outputs 0, instr_ready=1; issue NOP -> pc_q=1, done pulses once.
//  2. MOV_A_IMM 0xE, ADD_A_IMM 3 -> a_q=1, c_q=1; JNC_IMM 9 -> not taken, pc_q=3.
//  3. A=2, B=5, SUB_A_B -> a_q=0xD, c_q=1, z_q=0; ADD_A_IMM 3 -> a_q=0, z_q=1; JZ_IMM 7 -> pc_q=7.
//  4. A=7, B=5, MUL_A_B -> instr_ready low 4 cycles, extra valid ignored; a_q=3, b_q=2, z_q=0, one done.
//  5. rst asserted in the 2nd MUL cycle -> next cycle all state 0, instr_ready=1, no done pulse.
//  6. pc_q=15, OUT_B -> pc_q wraps to 0, out_q=b_q; IN_B with switch_in=0xA -> b_q=0xA, c_q=0.

Source files
------------

// File: rtl/exec_unit_pkg.sv
// Opcode/state encodings and the pure per-op next-state functions of the exec unit.
// Functions work on a generic REG_W-wide register set and mask results to the caller's widths.
package lib_operation;

    localparam int REG_W = 8;

    typedef enum logic [4:0] {
        NOP       = 5'd0,
        MOV_A_B   = 5'd1,
        MOV_B_A   = 5'd2,
        MOV_A_IMM = 5'd3,
        MOV_B_IMM = 5'd4,
        IN_A      = 5'd5,
        IN_B      = 5'd6,
        OUT_B     = 5'd7,
        OUT_IMM   = 5'd8,
        ADD_A_IMM = 5'd9,
        ADD_B_IMM = 5'd10,
        ADD_A_B   = 5'd11,
        SUB_A_B   = 5'd12,
        SHL_A     = 5'd13,
        SHR_A     = 5'd14,
        JMP_IMM   = 5'd15,
        JNC_IMM   = 5'd16,
        JZ_IMM    = 5'd17,
        MUL_A_B   = 5'd18
    } opecode_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef logic [REG_W-1:0] word_t;

    typedef struct packed {
        word_t a;
        word_t b;
        word_t out;
        word_t pc;
        logic  c;
        logic  z;
    } regs_t;

    function automatic word_t width_mask(input int w);
        word_t m;
        for (int i = 0; i < REG_W; i++) m[i] = (i < w);
        return m;
    endfunction

    function automatic word_t pc_inc(input word_t pc, input int pw);
        return (pc + word_t'(1)) & width_mask(pw);
    endfunction

    // Operands are already confined to dw bits, so any sum bit above dw-1 is the carry.
    function automatic logic [REG_W:0] add_dw(input word_t x, input word_t y, input int dw);
        logic [REG_W:0] t;
        word_t          dm;
        dm = width_mask(dw);
        t  = {1'b0, x} + {1'b0, y};
        return {|(t & ~{1'b0, dm}), t[REG_W-1:0] & dm};
    endfunction

    function automatic regs_t exec_step(input regs_t r, input opecode_t op, input word_t imm,
                                        input word_t sw, input int dw, input int pw);
        regs_t          n;
        logic [REG_W:0] t;
        word_t          dm;
        logic           taken;
        n     = r;
        n.c   = 1'b0;
        taken = 1'b0;
        t     = '0;
        dm    = width_mask(dw);
        case (op)
            MOV_A_B:   n.a = r.b;
            MOV_B_A:   n.b = r.a;
            MOV_A_IMM: n.a = imm & dm;
            MOV_B_IMM: n.b = imm & dm;
            IN_A:      n.a = sw & dm;
            IN_B:      n.b = sw & dm;
            OUT_B:     n.out = r.b;
            OUT_IMM:   n.out = imm & dm;
            ADD_A_IMM: begin
                t = add_dw(r.a, imm & dm, dw);
                {n.c, n.a} = t;
                n.z = (n.a == '0);
            end
            ADD_B_IMM: begin
                t = add_dw(r.b, imm & dm, dw);
                {n.c, n.b} = t;
                n.z = (n.b == '0);
            end
            ADD_A_B: begin
                t = add_dw(r.a, r.b, dw);
                {n.c, n.a} = t;
                n.z = (n.a == '0);
            end
            SUB_A_B: begin
                n.a = (r.a - r.b) & dm;
                n.c = (r.a < r.b);
                n.z = (n.a == '0);
            end
            SHL_A: begin
                n.c = |(r.a & dm & ~(dm >> 1));
                n.a = (r.a << 1) & dm;
                n.z = (n.a == '0);
            end
            SHR_A: begin
                n.c = r.a[0];
                n.a = r.a >> 1;
                n.z = (n.a == '0);
            end
            JMP_IMM:   taken = 1'b1;
            JNC_IMM:   taken = ~r.c;
            JZ_IMM:    taken = r.z;
            default:   ;
        endcase
        n.pc = taken ? (imm & width_mask(pw)) : pc_inc(r.pc, pw);
        return n;
    endfunction

endpackage

// File: rtl/exec_unit_seq_multiplier.sv
// Shift-add multiplier: one partial-product step per cycle, DATA_W steps per product.
// done/product are combinational during the last step so the owner can commit on that edge.
module seq_multiplier #(
    parameter int DATA_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [2*DATA_W-1:0] mcand;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_step;
    logic [DATA_W-1:0]   mplier;
    logic [CW-1:0]       cnt;

    assign acc_step = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_step;
    assign done     = busy && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            mcand  <= {{DATA_W{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= CW'(DATA_W - 1);
        end else if (busy) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) busy <= 1'b0;
            else           cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/exec_unit.sv
// Stateful exec unit: register file, flags, PC and the one-instruction handshake.
// state | meaning
// IDLE  | ready; single-cycle ops commit on the accepting edge
// MUL   | multiply in flight; A/B hold old values until the product commits
module exec_unit
    import lib_operation::*;
#(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  opecode_t          opecode,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] switch_in,
    output logic [DATA_W-1:0] a_q,
    output logic [DATA_W-1:0] b_q,
    output logic [DATA_W-1:0] out_q,
    output logic [PC_W-1:0]   pc_q,
    output logic              c_q,
    output logic              z_q,
    output logic              done
);
    regs_t               r;
    regs_t               nxt;
    state_t              state;
    logic                accept;
    logic                mul_start;
    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;
    logic                unused_hi;

    assign instr_ready = (state == IDLE) && !mul_busy;
    assign accept      = instr_valid && instr_ready;
    assign mul_start   = accept && (opecode == MUL_A_B);

    always_comb begin
        nxt = exec_step(r, opecode, word_t'(imm), word_t'(switch_in), DATA_W, PC_W);
    end

    seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (r.a[DATA_W-1:0]),
        .b       (r.b[DATA_W-1:0]),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r     <= '0;
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (opecode == MUL_A_B) begin
                            state <= MUL;
                        end else begin
                            r    <= nxt;
                            done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        r.a   <= word_t'(mul_product[DATA_W-1:0]);
                        r.b   <= word_t'(mul_product[2*DATA_W-1:DATA_W]);
                        r.c   <= 1'b0;
                        r.z   <= (mul_product == '0);
                        r.pc  <= pc_inc(r.pc, PC_W);
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a_q   = r.a[DATA_W-1:0];
    assign b_q   = r.b[DATA_W-1:0];
    assign out_q = r.out[DATA_W-1:0];
    assign pc_q  = r.pc[PC_W-1:0];
    assign c_q   = r.c;
    assign z_q   = r.z;

    // Upper bits of the generic-width register set are always masked to zero.
    assign unused_hi = ^{r.a[REG_W-1:DATA_W], r.b[REG_W-1:DATA_W],
                         r.out[REG_W-1:DATA_W], r.pc[REG_W-1:PC_W]};

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit (DATA_W=4, PC_W=4): a 4-bit reference model pushes the
// expected register set per accepted instruction and a monitor pops it on every done pulse.
module tb_exec_unit;
    import lib_operation::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    opecode_t   opecode;
    logic [3:0] imm;
    logic [3:0] switch_in;
    logic [3:0] a_q, b_q, out_q, pc_q;
    logic       c_q, z_q, done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] a, b, out, pc;
        logic       c, z;
    } exp_t;

    exp_t exp_q[$];

    logic [3:0] m_a, m_b, m_out, m_pc;
    logic       m_c, m_z;

    exec_unit #(.DATA_W(4), .PC_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opecode     (opecode),
        .imm         (imm),
        .switch_in   (switch_in),
        .a_q         (a_q),
        .b_q         (b_q),
        .out_q       (out_q),
        .pc_q        (pc_q),
        .c_q         (c_q),
        .z_q         (z_q),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 with nothing outstanding, required done=0 at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({a_q, b_q, out_q, pc_q, c_q, z_q} !== {e.a, e.b, e.out, e.pc, e.c, e.z}) begin
                    errors++;
                    $display("FAIL commit: got a=%h b=%h out=%h pc=%h c=%b z=%b, required a=%h b=%h out=%h pc=%h c=%b z=%b at %0t",
                             a_q, b_q, out_q, pc_q, c_q, z_q, e.a, e.b, e.out, e.pc, e.c, e.z, $time);
                end
            end
        end
    end

    task automatic model_exec(input opecode_t op, input logic [3:0] iv, input logic [3:0] sw);
        logic       oc, oz, jmp;
        logic [4:0] t;
        logic [7:0] p;
        oc  = m_c;
        oz  = m_z;
        jmp = 1'b0;
        m_c = 1'b0;
        case (op)
            MOV_A_B:   m_a = m_b;
            MOV_B_A:   m_b = m_a;
            MOV_A_IMM: m_a = iv;
            MOV_B_IMM: m_b = iv;
            IN_A:      m_a = sw;
            IN_B:      m_b = sw;
            OUT_B:     m_out = m_b;
            OUT_IMM:   m_out = iv;
            ADD_A_IMM: begin t = {1'b0, m_a} + {1'b0, iv};  {m_c, m_a} = t; m_z = (m_a == 4'h0); end
            ADD_B_IMM: begin t = {1'b0, m_b} + {1'b0, iv};  {m_c, m_b} = t; m_z = (m_b == 4'h0); end
            ADD_A_B:   begin t = {1'b0, m_a} + {1'b0, m_b}; {m_c, m_a} = t; m_z = (m_a == 4'h0); end
            SUB_A_B:   begin t = {1'b0, m_a} - {1'b0, m_b}; {m_c, m_a} = t; m_z = (m_a == 4'h0); end
            SHL_A:     begin m_c = m_a[3]; m_a = {m_a[2:0], 1'b0}; m_z = (m_a == 4'h0); end
            SHR_A:     begin m_c = m_a[0]; m_a = {1'b0, m_a[3:1]}; m_z = (m_a == 4'h0); end
            JMP_IMM:   jmp = 1'b1;
            JNC_IMM:   jmp = !oc;
            JZ_IMM:    jmp = oz;
            MUL_A_B:   begin p = {4'h0, m_a} * {4'h0, m_b}; m_a = p[3:0]; m_b = p[7:4]; m_z = (p == 8'h00); end
            default:   ;
        endcase
        m_pc = jmp ? iv : m_pc + 4'd1;
        exp_q.push_back('{a: m_a, b: m_b, out: m_out, pc: m_pc, c: m_c, z: m_z});
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        instr_valid = 1'b0;
        opecode     = NOP;
        imm         = 4'h0;
        switch_in   = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        {m_a, m_b, m_out, m_pc, m_c, m_z} = '0;
        @(negedge clk);
    endtask

    // One single-cycle instruction, issued at a negedge and released at the next one.
    task automatic send(input opecode_t op, input logic [3:0] iv, input logic [3:0] sw);
        opecode     = op;
        imm         = iv;
        switch_in   = sw;
        instr_valid = 1'b1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_at_issue: instr_ready=%b required 1 at %0t", instr_ready, $time);
        end
        @(posedge clk);
        model_exec(op, iv, sw);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic send_mul(input logic stray);
        logic [3:0] a0, b0;
        a0          = m_a;
        b0          = m_b;
        opecode     = MUL_A_B;
        instr_valid = 1'b1;
        @(posedge clk);
        model_exec(MUL_A_B, 4'h0, 4'h0);
        @(negedge clk);
        if (stray) begin
            opecode = MOV_A_IMM;
            imm     = 4'hF;
        end else begin
            instr_valid = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (instr_ready !== 1'b0) begin
                errors++;
                $display("FAIL mul_busy_ready: cycle %0d instr_ready=%b required 0", i, instr_ready);
            end
            checks++;
            if ({a_q, b_q, done} !== {a0, b0, 1'b0}) begin
                errors++;
                $display("FAIL mul_hold: cycle %0d a=%h b=%h done=%b required a=%h b=%h done=0", i, a_q, b_q, done, a0, b0);
            end
            if (i == 3) instr_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({instr_ready, done} !== 2'b11) begin
            errors++;
            $display("FAIL mul_commit_handshake: ready=%b done=%b required ready=1 done=1", instr_ready, done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({a_q, b_q, out_q, pc_q, c_q, z_q, done, instr_ready} !== {16'h0000, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: a=%h b=%h out=%h pc=%h c=%b z=%b done=%b ready=%b required zeros with ready=1",
                     a_q, b_q, out_q, pc_q, c_q, z_q, done, instr_ready);
        end
        send(NOP, 4'h0, 4'h0);
        checks++;
        if ({pc_q, done} !== {4'h1, 1'b1}) begin
            errors++;
            $display("FAIL nop_pc: pc=%h done=%b required pc=1 done=1", pc_q, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_add_jnc();
        do_reset();
        send(MOV_A_IMM, 4'hE, 4'h0);
        send(ADD_A_IMM, 4'h3, 4'h0);
        checks++;
        if ({a_q, c_q} !== {4'h1, 1'b1}) begin
            errors++;
            $display("FAIL add_carry: a=%h c=%b required a=1 c=1", a_q, c_q);
        end
        send(JNC_IMM, 4'h9, 4'h0);
        checks++;
        if (pc_q !== 4'h3) begin
            errors++;
            $display("FAIL jnc_not_taken: pc=%h required 3", pc_q);
        end
    endtask

    task automatic test_sub_jz();
        do_reset();
        send(MOV_A_IMM, 4'h2, 4'h0);
        send(MOV_B_IMM, 4'h5, 4'h0);
        send(SUB_A_B, 4'h0, 4'h0);
        checks++;
        if ({a_q, c_q, z_q} !== {4'hD, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: a=%h c=%b z=%b required a=d c=1 z=0", a_q, c_q, z_q);
        end
        send(ADD_A_IMM, 4'h3, 4'h0);
        checks++;
        if ({a_q, z_q} !== {4'h0, 1'b1}) begin
            errors++;
            $display("FAIL add_zero: a=%h z=%b required a=0 z=1", a_q, z_q);
        end
        send(JZ_IMM, 4'h7, 4'h0);
        checks++;
        if (pc_q !== 4'h7) begin
            errors++;
            $display("FAIL jz_taken: pc=%h required 7", pc_q);
        end
    endtask

    task automatic test_mul();
        do_reset();
        send(MOV_A_IMM, 4'h7, 4'h0);
        send(MOV_B_IMM, 4'h5, 4'h0);
        send_mul(1'b1);
        checks++;
        if ({a_q, b_q, z_q, c_q, pc_q} !== {4'h3, 4'h2, 1'b0, 1'b0, 4'h3}) begin
            errors++;
            $display("FAIL mul_result: a=%h b=%h z=%b c=%b pc=%h required a=3 b=2 z=0 c=0 pc=3", a_q, b_q, z_q, c_q, pc_q);
        end
        @(negedge clk);
    endtask

    task automatic test_mul_reset();
        do_reset();
        send(MOV_A_IMM, 4'h7, 4'h0);
        send(MOV_B_IMM, 4'h5, 4'h0);
        opecode     = MUL_A_B;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_q, b_q, out_q, pc_q, c_q, z_q, done, instr_ready} !== {16'h0000, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL mul_abort: a=%h b=%h out=%h pc=%h c=%b z=%b done=%b ready=%b required zeros with ready=1",
                     a_q, b_q, out_q, pc_q, c_q, z_q, done, instr_ready);
        end
        rst = 1'b0;
        exp_q.delete();
        {m_a, m_b, m_out, m_pc, m_c, m_z} = '0;
        repeat (6) @(negedge clk);
        checks++;
        if ({instr_ready, a_q, b_q, pc_q} !== {1'b1, 12'h000}) begin
            errors++;
            $display("FAIL mul_abort_quiet: ready=%b a=%h b=%h pc=%h required ready=1 a=0 b=0 pc=0", instr_ready, a_q, b_q, pc_q);
        end
    endtask

    task automatic test_wrap_io();
        do_reset();
        send(JMP_IMM, 4'hC, 4'h0);
        send(MOV_B_IMM, 4'h6, 4'h0);
        send(MOV_A_IMM, 4'hF, 4'h0);
        send(ADD_A_IMM, 4'h1, 4'h0);
        send(OUT_B, 4'h0, 4'h0);
        checks++;
        if ({pc_q, out_q, c_q} !== {4'h0, 4'h6, 1'b0}) begin
            errors++;
            $display("FAIL pc_wrap_out: pc=%h out=%h c=%b required pc=0 out=6 c=0", pc_q, out_q, c_q);
        end
        send(MOV_A_IMM, 4'hF, 4'h0);
        send(ADD_A_IMM, 4'h1, 4'h0);
        send(IN_B, 4'h0, 4'hA);
        checks++;
        if ({b_q, c_q} !== {4'hA, 1'b0}) begin
            errors++;
            $display("FAIL in_b: b=%h c=%b required b=a c=0", b_q, c_q);
        end
    endtask

    task automatic test_back_to_back();
        int r;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 31);
            if (r == 18) send_mul(1'b0);
            else send(opecode_t'(5'(r)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        send(MOV_A_IMM, 4'hB, 4'h0);
        send(MOV_B_IMM, 4'hD, 4'h0);
        send_mul(1'b0);
        send(SHL_A, 4'h0, 4'h0);
        send(SHR_A, 4'h0, 4'h0);
        send(ADD_A_B, 4'h0, 4'h0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add_jnc();
        test_sub_jz();
        test_mul();
        test_mul_reset();
        test_wrap_io();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: %0d commits outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
